avalon_regbank: RTL and testbench

Parametrised, byte-enabled Avalon-MM slave register bank holding NREGS registers of DATA_W bits. Each register is read/write, read-only (hardware-driven), or write-1-to-clear status (hardware-set sticky bits), with a registered one-cycle read path. It sits between the Nios II/SoC interconnect and custom peripherals on the DE10 board. It is the multi-register, multi-mode successor to the single 32-bit byte-enabled register.

---
 rtl/avalon_regbank_pkg.sv | 38 +++
 rtl/avalon_regbank_if.sv | 27 ++
 rtl/avalon_regbank_cell.sv | 46 ++++
 rtl/avalon_regbank.sv | 79 +++++++
 tb/tb_avalon_regbank.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/avalon_regbank_pkg.sv
// Shared definitions for the Avalon-MM register bank: register modes and
// elaboration-time helpers used to pick each register's mode.
package regbank_pkg;

  typedef enum logic [1:0] {
    MODE_RW  = 2'd0,
    MODE_RO  = 2'd1,
    MODE_W1C = 2'd2
  } mode_e;

  // Masks are widened to this many bits before mode lookup
  localparam int MAX_REGS = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Read-only takes precedence when a register appears in both masks
  function automatic mode_e mode_of(input int i,
                                    input logic [MAX_REGS-1:0] ro_mask,
                                    input logic [MAX_REGS-1:0] w1c_mask);
    logic [5:0] idx;
    idx = i[5:0];
    if (ro_mask[idx]) begin
      return MODE_RO;
    end
    if (w1c_mask[idx]) begin
      return MODE_W1C;
    end
    return MODE_RW;
  endfunction

endpackage

// File: rtl/avalon_regbank_if.sv
// Avalon-MM slave bus bundle (no waitrequest) for the register bank.
interface avalon_regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);

  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              write;
  logic              read;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, write, read, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, write, read, byteenable, writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/avalon_regbank_cell.sv
// One DATA_W register of the bank; behaves as RW, RO or W1C according to
// its mode, which is fixed per instance at elaboration.
module regbank_cell
  import regbank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  mode_e             mode,
  input  logic              wr_en,
  input  logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] hw_in,
  input  logic [DATA_W-1:0] hw_set,
  output logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] wmask;

  // Bit-level write mask: an addressed write expanded by its byte enables
  always_comb begin
    wmask = '0;
    for (int b = 0; b < BE_W; b++) begin
      wmask[b*8 +: 8] = {8{wr_en & byteenable[b]}};
    end
  end

  // In W1C mode a coincident set beats the clear, so set is OR-ed in last
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else begin
      case (mode)
        MODE_RW:  value <= (value & ~wmask) | (writedata & wmask);
        MODE_W1C: value <= (value & ~(writedata & wmask)) | hw_set;
        default:  value <= '0;
      endcase
    end
  end

  assign rdata = (mode == MODE_RO) ? hw_in : value;

endmodule

// File: rtl/avalon_regbank.sv
// Byte-enabled Avalon-MM register bank: address decode, per-register cells,
// one-cycle registered read path and W1C interrupt reduction.
module avalon_regbank
  import regbank_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               NREGS    = 8,
  parameter logic [NREGS-1:0] RO_MASK  = '0,
  parameter logic [NREGS-1:0] W1C_MASK = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  avalon_regbank_if.slave         bus,
  input  logic [NREGS*DATA_W-1:0] hw_in,
  input  logic [NREGS*DATA_W-1:0] hw_set,
  output logic [NREGS*DATA_W-1:0] q,
  output logic                    irq
);

  localparam int BE_W   = DATA_W / 8;
  localparam int ADDR_W = (clog2(NREGS) > 1) ? clog2(NREGS) : 1;

  logic [NREGS-1:0]  hit;
  logic [NREGS-1:0]  w1c_active;
  logic [DATA_W-1:0] rd_vals [NREGS];
  logic [DATA_W-1:0] rd_mux;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam mode_e MODE = mode_of(i, MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK));

    logic [DATA_W-1:0] cell_value;

    assign hit[i] = (bus.address == ADDR_W'(i));

    regbank_cell #(
      .DATA_W (DATA_W),
      .BE_W   (BE_W)
    ) u_cell (
      .clock      (clock),
      .reset      (reset),
      .mode       (MODE),
      .wr_en      (bus.write & hit[i]),
      .byteenable (bus.byteenable),
      .writedata  (bus.writedata),
      .hw_in      (hw_in[i*DATA_W +: DATA_W]),
      .hw_set     (hw_set[i*DATA_W +: DATA_W]),
      .value      (cell_value),
      .rdata      (rd_vals[i])
    );

    assign q[i*DATA_W +: DATA_W] = cell_value;
    assign w1c_active[i]         = (MODE == MODE_W1C) ? |cell_value : 1'b0;
  end

  assign irq = |w1c_active;

  // Addresses past the last register match nothing and read back as zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (hit[i]) begin
        rd_mux = rd_vals[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
    end else begin
      bus.readdatavalid <= bus.read;
      if (bus.read) begin
        bus.readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_avalon_regbank.sv
// Self-checking bench for avalon_regbank: directed scenarios followed by
// randomized traffic, all compared against a behavioural register model.
module tb_avalon_regbank;

  localparam int               DW  = 32;
  localparam int               NR  = 10;
  localparam int               AW  = 4;
  localparam int               QW  = NR * DW;
  localparam logic [NR-1:0]    RO  = 10'h108;
  localparam logic [NR-1:0]    W1C = 10'h1A0;

  logic          clock = 1'b0;
  logic          reset;
  logic [QW-1:0] hw_in;
  logic [QW-1:0] hw_set;
  logic [QW-1:0] q;
  logic          irq;

  avalon_regbank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  avalon_regbank #(
    .DATA_W   (DW),
    .NREGS    (NR),
    .RO_MASK  (RO),
    .W1C_MASK (W1C)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .hw_in  (hw_in),
    .hw_set (hw_set),
    .q      (q),
    .irq    (irq)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_rdata;
  logic          m_valid;
  int            compared   = 0;
  int            mismatched = 0;

  task automatic checkOutput(input string tag, input logic [QW-1:0] actual,
                             input logic [QW-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [QW-1:0] modelQ();
    logic [QW-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) begin
      v[i*DW +: DW] = RO[i] ? '0 : m_regs[i];
    end
    return v;
  endfunction

  function automatic logic modelIrq();
    logic r;
    r = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (!RO[i] && W1C[i] && (m_regs[i] != '0)) r = 1'b1;
    end
    return r;
  endfunction

  // Register behaviour straight from the bank's rules, applied once per edge
  task automatic modelStep(input logic rst, input logic rd, input logic wr,
                           input logic [AW-1:0] addr, input logic [3:0] be,
                           input logic [DW-1:0] wd);
    logic [DW-1:0] bemask;
    logic [DW-1:0] clr;
    int            a;
    a = int'(addr);
    for (int b = 0; b < 4; b++) bemask[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_rdata = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = rd;
      if (rd) begin
        if (a >= NR)    m_rdata = '0;
        else if (RO[a]) m_rdata = hw_in[a*DW +: DW];
        else            m_rdata = m_regs[a];
      end
      for (int i = 0; i < NR; i++) begin
        if (RO[i]) begin
          m_regs[i] = '0;
        end else if (W1C[i]) begin
          clr = (wr && a == i) ? (wd & bemask) : '0;
          m_regs[i] = (m_regs[i] & ~clr) | hw_set[i*DW +: DW];
        end else if (wr && a == i) begin
          m_regs[i] = (m_regs[i] & ~bemask) | (wd & bemask);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rd, input logic wr,
                               input logic [AW-1:0] addr, input logic [3:0] be,
                               input logic [DW-1:0] wd);
    reset          = rst;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = addr;
    bus.byteenable = be;
    bus.writedata  = wd;
    @(posedge clock);
    modelStep(rst, rd, wr, addr, be, wd);
    #1;
    checkOutput("readdatavalid", QW'(bus.readdatavalid), QW'(m_valid));
    checkOutput("readdata", QW'(bus.readdata), QW'(m_rdata));
    checkOutput("q", q, modelQ());
    checkOutput("irq", QW'(irq), QW'(modelIrq()));
  endtask

  initial begin
    hw_in  = '0;
    hw_set = '0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_rdata = '0;
    m_valid = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset_q", q, '0);
    checkOutput("reset_irq", QW'(irq), '0);

    // Back-to-back reads across every address, in and out of range
    for (int a = 0; a < 16; a++) begin
      applyStimulus(0, 1, 0, AW'(a), 0, 0);
      checkOutput("reset_read_valid", QW'(bus.readdatavalid), QW'(1'b1));
      checkOutput("reset_read_data", QW'(bus.readdata), '0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("valid_drops", QW'(bus.readdatavalid), '0);

    applyStimulus(0, 0, 1, 2, 4'b1111, 32'hAABBCCDD);
    checkOutput("rw2_q_full", QW'(q[2*DW +: DW]), QW'(32'hAABBCCDD));
    applyStimulus(0, 0, 1, 2, 4'b0101, 32'h11223344);
    checkOutput("rw2_q_partial", QW'(q[2*DW +: DW]), QW'(32'hAA22CC44));
    applyStimulus(0, 1, 0, 2, 0, 0);
    checkOutput("rw2_read", QW'(bus.readdata), QW'(32'hAA22CC44));

    hw_in[3*DW +: DW] = 32'h12345678;
    applyStimulus(0, 0, 1, 3, 4'b1111, 32'hFFFFFFFF);
    applyStimulus(0, 1, 0, 3, 0, 0);
    checkOutput("ro3_read", QW'(bus.readdata), QW'(32'h12345678));
    checkOutput("ro3_q", QW'(q[3*DW +: DW]), '0);

    hw_set[5*DW +: DW] = 32'h81;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("w1c5_set", QW'(q[5*DW +: DW]), QW'(32'h81));
    checkOutput("w1c5_irq_on", QW'(irq), QW'(1'b1));
    hw_set[5*DW +: DW] = 32'h01;
    applyStimulus(0, 0, 1, 5, 4'b0001, 32'h01);
    hw_set = '0;
    checkOutput("w1c5_set_wins", QW'(q[5*DW +: DW]), QW'(32'h81));
    applyStimulus(0, 0, 1, 5, 4'b0000, 32'hFF);
    checkOutput("w1c5_be0", QW'(q[5*DW +: DW]), QW'(32'h81));
    applyStimulus(0, 0, 1, 5, 4'b0001, 32'h81);
    checkOutput("w1c5_clear", QW'(q[5*DW +: DW]), '0);
    checkOutput("w1c5_irq_off", QW'(irq), '0);

    // Register 8 sits in both masks and must act read-only
    hw_set[8*DW +: DW] = 32'hFF;
    applyStimulus(0, 0, 0, 0, 0, 0);
    hw_set = '0;
    checkOutput("ro_wins_q", QW'(q[8*DW +: DW]), '0);
    checkOutput("ro_wins_irq", QW'(irq), '0);

    applyStimulus(0, 0, 1, 1, 4'b1111, 32'h5);
    applyStimulus(0, 1, 1, 1, 4'b1111, 32'h9);
    checkOutput("rw_same_cycle_old", QW'(bus.readdata), QW'(32'h5));
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("rw_same_cycle_new", QW'(bus.readdata), QW'(32'h9));

    applyStimulus(0, 0, 1, 9, 4'b1111, 32'hCAFE);
    applyStimulus(0, 1, 0, 9, 0, 0);
    checkOutput("read_last_reg", QW'(bus.readdata), QW'(32'hCAFE));
    applyStimulus(0, 1, 1, 12, 4'b1111, 32'hDEAD);
    checkOutput("read_oob_data", QW'(bus.readdata), '0);
    checkOutput("read_oob_valid", QW'(bus.readdatavalid), QW'(1'b1));

    applyStimulus(1, 1, 1, 1, 4'b1111, 32'h77);
    checkOutput("rst_rd_valid", QW'(bus.readdatavalid), '0);
    checkOutput("rst_rd_data", QW'(bus.readdata), '0);
    checkOutput("rst_wr_q", q, '0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst_rd_no_late_valid", QW'(bus.readdatavalid), '0);

    // Randomized traffic with sparse hardware set pulses and rare resets
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NR; k++) begin
        hw_in[k*DW +: DW]  = $urandom();
        hw_set[k*DW +: DW] = ($urandom_range(0, 3) == 0) ?
                             ($urandom() & $urandom() & $urandom()) : 32'h0;
      end
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                    4'($urandom()), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
